// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, constants, types and PC helpers for the core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int INS_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_INC           = 16'd4;

    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Word-sequential successor; wraps silently at the top of the address space.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small instruction buffer of {ins, pc} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Credit-based instruction fetch with a 2-entry decode buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INS_W-1:0]  id_ins,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pending_pc;
    logic              r_pending;

    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occupancy;
    logic [OCC_W-1:0]  w_limit;
    logic              w_pop;
    logic              w_push;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    assign w_pop  = id_valid & id_ready;
    assign w_push = r_pending & ~redirect_valid;

    // Buffered plus in-flight words must stay below the buffer size after this cycle's pop.
    assign w_occupancy = OCC_W'(w_count) + OCC_W'(r_pending);
    assign w_limit     = OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop);
    assign imem_en     = ~rst & ~redirect_valid & (w_occupancy < w_limit);
    assign imem_addr   = r_fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc   <= pc_align(RESET_PC);
            r_pending_pc <= pc_align(RESET_PC);
            r_pending    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= pc_align(redirect_pc);
            r_pending  <= 1'b0;
        end else if (imem_en) begin
            r_pending    <= 1'b1;
            r_pending_pc <= r_fetch_pc;
            r_fetch_pc   <= pc_next(r_fetch_pc);
        end else begin
            r_pending <= 1'b0;
        end
    end

    assign w_push_data.ins = imem_rdata;
    assign w_push_data.pc  = r_pending_pc;

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign id_valid    = (w_count != '0);
    assign id_ins      = w_head.ins;
    assign id_pc       = w_head.pc;
    assign id_pc_plus4 = pc_next(w_head.pc);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_ins;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus4;

    fetch_stage #(
        .RESET_PC       (RST_PC),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ins         (id_ins),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: the address itself, or a scrambled word later on.
    logic word_mode = 1'b0;
    function automatic logic [31:0] word_of(input logic [15:0] a);
        return word_mode ? {a ^ 16'h9E37, ~a} : {16'h0000, a};
    endfunction

    // Synchronous-read memory; garbage on cycles without a request.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? word_of(imem_addr) : $urandom;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream model: words delivered run sequentially from the latest redirect/reset target.
    int          buffered  = 0;
    int          in_flight = 0;
    int          delivered = 0;
    logic [15:0] exp_pc    = RST_PC;
    logic [15:0] exp_issue = RST_PC;

    task automatic model_reset();
        buffered  = 0;
        in_flight = 0;
        exp_pc    = RST_PC;
        exp_issue = RST_PC;
    endtask

    task automatic cycle(input logic rdy, input logic rv, input logic [15:0] rpc);
        logic vld, pop, en;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        vld = (buffered > 0);
        pop = vld && rdy;
        en  = !rv && ((buffered + in_flight - int'(pop)) < 2);
        check("id_valid", 32'(id_valid), 32'(vld));
        check("imem_en", 32'(imem_en), 32'(en));
        if (en) check("imem_addr", 32'(imem_addr), 32'(exp_issue));
        if (vld) begin
            check("id_pc", 32'(id_pc), 32'(exp_pc));
            check("id_ins", id_ins, word_of(exp_pc));
            check("id_pc_plus4", 32'(id_pc_plus4), 32'(16'(exp_pc + 16'd4)));
        end
        if (pop) begin
            delivered++;
            exp_pc = exp_pc + 16'd4;
        end
        if (rv) begin
            buffered  = 0;
            in_flight = 0;
            exp_pc    = rpc & 16'hFFFC;
            exp_issue = rpc & 16'hFFFC;
        end else begin
            buffered  = buffered - int'(pop) + in_flight;
            in_flight = en ? 1 : 0;
            if (en) exp_issue = exp_issue + 16'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted between edges must clear the outputs without waiting for a clock.
    task automatic reset_pulse();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_id_valid", 32'(id_valid), 32'd0);
        check("async_rst_imem_en", 32'(imem_en), 32'd0);
        word_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        rst = 1'b0;
        model_reset();

        // Free run until pc 8 sits at the head, then stall decode for 5 cycles.
        n = 0;
        while (!(buffered > 0 && exp_pc == 16'h0008) && n < 20) begin
            cycle(1'b1, 1'b0, 16'h0);
            n++;
        end
        check("reach_pc8", 32'(n < 20), 32'd1);
        repeat (5) cycle(1'b0, 1'b0, 16'h0);
        repeat (10) cycle(1'b1, 1'b0, 16'h0);

        // Redirect with the buffer full.
        n = 0;
        while (buffered != 2 && n < 10) begin
            cycle(1'b0, 1'b0, 16'h0);
            n++;
        end
        check("buffer_full", 32'(buffered), 32'd2);
        cycle(1'b0, 1'b1, 16'h0041);
        repeat (8) cycle(1'b1, 1'b0, 16'h0);

        // Address wrap at the top of memory.
        cycle(1'b1, 1'b1, 16'hFFF8);
        repeat (8) cycle(1'b1, 1'b0, 16'h0);

        // Redirect on a handshake, then a second redirect straight after.
        check("handshake_ready", 32'(buffered > 0), 32'd1);
        cycle(1'b1, 1'b1, 16'h1230);
        cycle(1'b1, 1'b1, 16'h2004);
        repeat (8) cycle(1'b1, 1'b0, 16'h0);

        // Asynchronous reset mid-stream, then restart.
        reset_pulse();
        repeat (10) cycle(1'b1, 1'b0, 16'h0);

        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            logic        rdy, rv;
            logic [15:0] t;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            t   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFE0 + 16'($urandom_range(0, 31)))
                                              : 16'($urandom);
            cycle(rdy, rv, t);
            if (i == 300) reset_pulse();
        end
        check("random_progress", 32'(delivered > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, 2: number of instruction buffer entries; fixed at 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_en  output  1  fetch request to the instruction memory this cycle.
REQ-006 imem_addr  output  16  byte address of the request; bits [1:0] always 0.
REQ-007 imem_rdata  input  32  instruction word, valid the cycle after imem_en (synchronous read).
REQ-008 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-009 redirect_pc  input  16  redirect target byte address.
REQ-010 id_valid  output  1  an instruction is offered to decode.
REQ-011 id_ready  input  1  decode accepts the offered instruction.
REQ-012 id_ins  output  32  offered instruction word.
REQ-013 id_pc  output  16  byte address of id_ins.
REQ-014 id_pc_plus4  output  16  id_pc + 4, modulo 2^16.

Function
REQ-015 fetch_pc register: imem_addr = fetch_pc, combinationally.
REQ-016 credit rule: imem_en = 1 when (fifo_count + pending - pop) < 2; pop = id_valid & id_ready; no redirect in the same cycle.
REQ-017 issue: on an edge where imem_en = 1, pending <= 1, pending_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
REQ-018 no issue: on an edge where imem_en = 0, fetch_pc holds and pending <= 0.
REQ-019 capture: on an edge where pending = 1, {imem_rdata, pending_pc} is pushed to the FIFO tail.
REQ-020 arithmetic: PC increment is 16-bit unsigned; 16'hFFFC + 4 wraps to 16'h0000 with no flag.
REQ-021 output: id_valid = (fifo_count != 0); id_ins/id_pc/id_pc_plus4 come from the FIFO head and are stable while id_valid & !id_ready.
REQ-022 simultaneous push and pop in one edge is legal; fifo_count is unchanged.
REQ-023 FIFO never overflows: the credit rule guarantees a push never meets a full FIFO.
REQ-024 throughput: with id_ready held high and no redirect, one instruction is delivered per cycle.
REQ-025 redirect: on an edge with redirect_valid = 1, the FIFO is cleared, pending <= 0 (the in-flight response is discarded) and fetch_pc <= {redirect_pc[15:2], 2'b00}.
REQ-026 redirect and pop in the same cycle: the handshake completes, then the flush applies.
REQ-027 redirect suppresses imem_en in its own cycle.
REQ-028 redirect latency: after redirect edge E, the target is requested in cycle E..E+1, captured at E+2 and id_valid is high after E+2.
REQ-029 back-to-back redirects: the latest one wins, and no instruction from an earlier target is delivered.

Reset
REQ-030 rst asserted: fetch_pc = RESET_PC, pending = 0, fifo_count = 0, id_valid = 0, imem_en = 0, immediately and asynchronously.
REQ-031 reset mid-operation discards all buffered and in-flight instructions.
REQ-032 first request at RESET_PC is issued in the first cycle after rst deasserts; first id_valid follows two edges later.

Structure
REQ-033 A shared package cpu_pkg holds: ADDR_W = 16, INS_W = 32, RESET_PC default, and the PC increment constant 4.
REQ-034 A single sub-module fetch_fifo (2-entry, {ins, pc} wide) holds the buffer, with push/pop/flush ports and a count output.
REQ-035 No combinational path runs from imem_rdata to any output.

Verification
REQ-036 Reset then id_ready = 1, imem returns word = address -> id_pc 0,4,8,... on consecutive cycles; id_ins = id_pc; first id_valid 2 edges after reset release.
REQ-037 id_ready low for 5 cycles from id_pc = 8 -> id_pc holds 8; imem_en drops after the FIFO fills; id_pc 8,12,16 in order after release, with none lost or duplicated.
REQ-038 Redirect to 16'h0041 while two entries are buffered -> next delivered id_pc = 16'h0040, 2 edges later; buffered and in-flight words never appear.
REQ-039 fetch_pc = 16'hFFF8, free-running -> id_pc FFF8, FFFC, 0000; id_pc_plus4 at FFFC = 0000.
REQ-040 Redirect coincident with a handshake, followed by a second redirect the next cycle -> only the second target is delivered.
REQ-041 rst pulsed mid-stream, asynchronously between edges -> id_valid = 0 immediately; fetch restarts at RESET_PC.
